jtag_drv: RTL and testbench

- Host-side JTAG driver on the system clock; sits directly upstream of the TAP controller.
- Accepts commands: TAP reset, IR shift, DR shift, idle clocking.
- Generates tck/tms/tdi toward the TAP, samples its tdo, and returns captured shift data on a response handshake.
- Lets clk-domain test logic drive IDCODE/BYPASS/SAMPLE/PRELOAD/INTEST/EXTEST sequences without hand-toggling pins.

---
 rtl/jtag_drv_if.sv | 31 +++
 rtl/jtag_drv.sv | 217 +++++++++++++++++++++
 tb/tb_jtag_drv.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_drv_if.sv
// ============================================================================
// jtag_drv_if : command/response handshake bundle for the jtag_drv driver
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface jtag_drv_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/jtag_drv.sv
// ============================================================================
// jtag_drv : host-side JTAG driver generating tck/tms/tdi from clk-domain cmds
//            Optional JTAG_DRV_TCKCNT_EN adds a saturating tck rise counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jtag_drv #(
  parameter int TCK_DIV = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  jtag_drv_if.slave  bus,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       tdo,
  output logic       busy
`ifdef JTAG_DRV_TCKCNT_EN
  ,
  output logic [15:0] tck_count
`endif
);

  localparam logic [1:0] c_OP_RESET = 2'b00;
  localparam logic [1:0] c_OP_IR    = 2'b01;
  localparam logic [1:0] c_OP_DR    = 2'b10;
  localparam logic [1:0] c_OP_IDLE  = 2'b11;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_PRE   = 3'd1;
  localparam logic [2:0] c_ST_SHIFT = 3'd2;
  localparam logic [2:0] c_ST_POST  = 3'd3;
  localparam logic [2:0] c_ST_RSP   = 3'd4;

  localparam int c_DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic               r_rdy_en;
  logic               r_synced;
  logic               r_post;
  logic [1:0]         r_op;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_bit;
  logic [LEN_W-1:0]   w_len;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_cap;
  logic [MAX_LEN-1:0] r_rsp;
  logic [10:0]        r_pat;
  logic [10:0]        w_pat;
  logic [3:0]         r_pre_cnt;
  logic [3:0]         w_pre_cnt;
  logic [c_DIV_W-1:0] r_div;
  logic               w_accept;
  logic               w_active;
  logic               w_phase_end;
  logic               w_rise;
  logic               w_pulse_end;
  logic               w_last_bit;

  assign w_accept    = bus.cmd_valid && bus.cmd_ready;
  assign w_active    = (r_state == c_ST_PRE) || (r_state == c_ST_SHIFT) || (r_state == c_ST_POST);
  assign w_phase_end = w_active && (r_div == c_DIV_W'(TCK_DIV - 1));
  assign w_rise      = w_phase_end && !tck;
  assign w_pulse_end = w_phase_end && tck;
  assign w_last_bit  = (r_bit == (r_len - LEN_W'(1)));

  // Zero length behaves as one bit; oversize lengths clamp to the data width
  always_comb begin
    w_len = bus.cmd_len;
    if (bus.cmd_len == '0)
      w_len = LEN_W'(1);
    else if (bus.cmd_len > LEN_W'(MAX_LEN))
      w_len = LEN_W'(MAX_LEN);
  end

  // PRE tms pattern, LSB first; an unsynced shift carries the TAP reset in front
  always_comb begin
    w_pat     = '0;
    w_pre_cnt = '0;
    case (bus.cmd_op)
      c_OP_RESET: begin w_pat = 11'b000_0011_1111; w_pre_cnt = 4'd7; end
      c_OP_IR: begin
        if (r_synced) begin w_pat = 11'b000_0000_0011; w_pre_cnt = 4'd4; end
        else          begin w_pat = 11'b001_1011_1111; w_pre_cnt = 4'd11; end
      end
      c_OP_DR: begin
        if (r_synced) begin w_pat = 11'b000_0000_0001; w_pre_cnt = 4'd3; end
        else          begin w_pat = 11'b000_1011_1111; w_pre_cnt = 4'd10; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept) w_next = (bus.cmd_op == c_OP_IDLE) ? c_ST_SHIFT : c_ST_PRE;
      c_ST_PRE:   if (w_pulse_end && (r_pre_cnt == 4'd1))
                    w_next = (r_op == c_OP_RESET) ? c_ST_RSP : c_ST_SHIFT;
      c_ST_SHIFT: if (w_pulse_end && w_last_bit)
                    w_next = (r_op == c_OP_IDLE) ? c_ST_RSP : c_ST_POST;
      c_ST_POST:  if (w_pulse_end && r_post) w_next = c_ST_RSP;
      c_ST_RSP:   if (bus.rsp_ready) w_next = c_ST_IDLE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = r_rdy_en && (r_state == c_ST_IDLE);
    bus.rsp_valid = (r_state == c_ST_RSP);
    bus.rsp_data  = r_rsp;
    busy          = w_active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      r_rdy_en  <= 1'b0;
      r_synced  <= 1'b0;
      r_post    <= 1'b0;
      r_op      <= '0;
      r_len     <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_cap     <= '0;
      r_rsp     <= '0;
      r_pat     <= '0;
      r_pre_cnt <= '0;
      r_div     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_op      <= bus.cmd_op;
        r_len     <= w_len;
        r_data    <= bus.cmd_data;
        r_cap     <= '0;
        r_bit     <= '0;
        r_div     <= '0;
        r_post    <= 1'b0;
        r_pat     <= w_pat;
        r_pre_cnt <= w_pre_cnt;
        tdi       <= 1'b0;
        tms       <= (bus.cmd_op == c_OP_IDLE) ? 1'b0 : w_pat[0];
        if (bus.cmd_op != c_OP_IDLE) r_synced <= 1'b1;
      end else if (w_active) begin
        if (!w_phase_end) begin
          r_div <= r_div + c_DIV_W'(1);
        end else if (!tck) begin
          r_div <= '0;
          tck   <= 1'b1;
          // Captured bits enter at the top and are right-aligned at the end
          if ((r_state == c_ST_SHIFT) && (r_op != c_OP_IDLE))
            r_cap <= {tdo, r_cap[MAX_LEN-1:1]};
        end else begin
          r_div <= '0;
          tck   <= 1'b0;
          case (r_state)
            c_ST_PRE: begin
              if (r_pre_cnt != 4'd1) begin
                r_pat     <= r_pat >> 1;
                r_pre_cnt <= r_pre_cnt - 4'd1;
                tms       <= r_pat[1];
              end else if (r_op != c_OP_RESET) begin
                tms <= (r_len == LEN_W'(1));
                tdi <= r_data[0];
              end
            end
            c_ST_SHIFT: begin
              if (!w_last_bit) begin
                r_bit  <= r_bit + LEN_W'(1);
                r_data <= r_data >> 1;
                tms    <= (r_op != c_OP_IDLE) && ((r_bit + LEN_W'(2)) == r_len);
                tdi    <= (r_op != c_OP_IDLE) && r_data[1];
              end else begin
                tms <= (r_op != c_OP_IDLE);
                tdi <= 1'b0;
              end
            end
            c_ST_POST: begin
              if (!r_post) begin
                r_post <= 1'b1;
                tms    <= 1'b0;
              end
            end
            default: ;
          endcase
          if (w_next == c_ST_RSP)
            r_rsp <= ((r_op == c_OP_IR) || (r_op == c_OP_DR)) ?
                     (r_cap >> (MAX_LEN - int'(r_len))) : '0;
        end
      end
    end
  end

`ifdef JTAG_DRV_TCKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tck_count <= '0;
    else if (w_rise && (tck_count != 16'hFFFF))
      tck_count <= tck_count + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_drv.sv
// ============================================================================
// tb_jtag_drv : scoreboard bench for jtag_drv with a behavioural IEEE 1149.1 TAP
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_jtag_drv;

  localparam int          c_TCK_DIV = 2;
  localparam int          c_MAX_LEN = 32;
  localparam int          c_LEN_W   = 6;
  localparam logic [1:0]  c_OP_RESET = 2'b00;
  localparam logic [1:0]  c_OP_IR    = 2'b01;
  localparam logic [1:0]  c_OP_DR    = 2'b10;
  localparam logic [1:0]  c_OP_IDLE  = 2'b11;
  localparam logic [31:0] c_IDCODE   = 32'h4BA0_0477;

  typedef struct {
    logic [31:0] data;
    int          pulses;
    logic [63:0] tms;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi, busy;
  logic tdo_r = 1'b0;
`ifdef JTAG_DRV_TCKCNT_EN
  logic [15:0] tck_count;
`endif

  jtag_drv_if #(.MAX_LEN(c_MAX_LEN), .LEN_W(c_LEN_W)) bus ();

  jtag_drv #(.TCK_DIV(c_TCK_DIV), .MAX_LEN(c_MAX_LEN), .LEN_W(c_LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo_r),
    .busy  (busy)
`ifdef JTAG_DRV_TCKCNT_EN
    ,
    .tck_count (tck_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];
  logic tb_synced = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural TAP ----------------
  localparam logic [3:0] TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                         PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                         SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;
  logic [3:0]  tap_st = TLR;
  logic [4:0]  tap_ir = 5'b00001;
  logic [4:0]  ir_sh  = '0;
  logic [31:0] dr_sh  = '0;
  logic        byp    = 1'b0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR:   tap_ir <= 5'b00001;
      CAPIR: ir_sh  <= 5'b00001;
      SHIR:  ir_sh  <= {tdi, ir_sh[4:1]};
      UPIR:  tap_ir <= ir_sh;
      CAPDR: begin dr_sh <= c_IDCODE; byp <= 1'b0; end
      SHDR:  begin dr_sh <= {tdi, dr_sh[31:1]}; byp <= tdi; end
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo_r <= (tap_st == SHIR) ? ir_sh[0] :
             (tap_st == SHDR) ? ((tap_ir == 5'b00001) ? dr_sh[0] : byp) : 1'b0;

  // ---------------- expected-value model ----------------
  function automatic exp_t mk_exp(input logic [1:0] op, input int len, input logic [31:0] rsp);
    exp_t e;
    int   k;
    int   n;
    n = (len == 0) ? 1 : ((len > c_MAX_LEN) ? c_MAX_LEN : len);
    e.data = rsp;
    e.tms  = '0;
    k = 0;
    if (op == c_OP_RESET || (op != c_OP_IDLE && !tb_synced)) begin
      for (int i = 0; i < 6; i++) begin e.tms[k] = 1'b1; k++; end
      k++;
    end
    if (op == c_OP_IR) begin e.tms[k] = 1'b1; e.tms[k+1] = 1'b1; k += 4; end
    if (op == c_OP_DR) begin e.tms[k] = 1'b1; k += 3; end
    if (op == c_OP_IDLE) k += n;
    else if (op != c_OP_RESET) begin
      k += n - 1;
      e.tms[k]   = 1'b1;
      e.tms[k+1] = 1'b1;
      k += 3;
    end
    e.pulses = k;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        in_cmd = 1'b0;
  logic        tck_q  = 1'b0;
  int          mon_pulses = 0;
  int          mon_busy   = 0;
  int          mon_leak   = 0;
  logic [63:0] mon_tms    = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_cmd = 1'b0;
      tck_q  = 1'b0;
    end else begin
      if (in_cmd) begin
        if (tck && !tck_q) begin
          if (mon_pulses < 64) mon_tms[mon_pulses] = tms;
          mon_pulses++;
        end
        if (busy) mon_busy++;
        if (bus.cmd_ready) mon_leak++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_data", bus.rsp_data, e.data);
          check("pulses", mon_pulses, e.pulses);
          check("tms_seq", mon_tms, e.tms);
          check("busy_cycles", mon_busy, e.pulses * 2 * c_TCK_DIV);
          check("cmd_ready_low", mon_leak, 0);
        end
        in_cmd = 1'b0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        in_cmd     = 1'b1;
        mon_pulses = 0;
        mon_busy   = 0;
        mon_leak   = 0;
        mon_tms    = '0;
      end
      tck_q = tck;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = c_LEN_W'(len);
    bus.cmd_data  = data;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) check("cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      check("rsp_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                         input logic [31:0] rsp);
    q.push_back(mk_exp(op, len, rsp));
    if (op != c_OP_IDLE) tb_synced = 1'b1;
    send_cmd(op, len, data);
    wait_done();
  endtask

  initial begin
    int n;
    int bad;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", bus.cmd_ready, 1'b1);

    // unsynced IR shift gets the TAP reset prepended (18 pulses)
    run_cmd(c_OP_IR, 5, 32'h01, 32'h01);
    run_cmd(c_OP_RESET, 0, 32'h0, 32'h0);
    run_cmd(c_OP_IR, 5, 32'h01, 32'h01);
    run_cmd(c_OP_DR, 32, 32'h0, c_IDCODE);
    run_cmd(c_OP_IR, 5, 32'h07, 32'h01);
    run_cmd(c_OP_DR, 4, 32'hB, 32'h6);
    run_cmd(c_OP_DR, 0, 32'h1, 32'h0);
    run_cmd(c_OP_DR, 40, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_cmd(c_OP_IDLE, 3, 32'hFFFF_FFFF, 32'h0);
    run_cmd(c_OP_IDLE, 0, 32'h0, 32'h0);
    run_cmd(c_OP_IDLE, 40, 32'h0, 32'h0);

    // response held back while a second command waits
    bus.rsp_ready = 1'b0;
    q.push_back(mk_exp(c_OP_DR, 4, 32'hA));
    send_cmd(c_OP_DR, 4, 32'h5);
    n = 0;
    while (!bus.rsp_valid && n < 1000) begin @(negedge clk); n++; end
    check("hold_rsp_arrive", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    q.push_back(mk_exp(c_OP_IDLE, 2, 32'h0));
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = c_OP_IDLE;
    bus.cmd_len   = 6'd2;
    bus.cmd_data  = '0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 32'hA || bus.cmd_ready || tck) bad++;
    end
    check("hold_stable", bad, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!(bus.cmd_valid && bus.cmd_ready) && n < 20) begin @(negedge clk); n++; end
    check("accept_after_rsp", n, 2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_done();

    // reset during the 3rd shift bit of a DR shift
    send_cmd(c_OP_DR, 8, 32'h0);
    n = 0;
    while (mon_pulses < 6 && n < 500) begin @(negedge clk); n++; end
    check("midrst_reach_bit3", mon_pulses, 6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tb_synced = 1'b0;
    #1;
    check("midrst_tck", tck, 1'b0);
    check("midrst_tms", tms, 1'b1);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    check("midrst_rsp_data", bus.rsp_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cmd(c_OP_DR, 8, 32'h0, {24'h0, c_IDCODE[7:0]});

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
